// File: rtl/axi4_read_responder.sv
// Single-request read responder backed by a word array with fixed response latency.
// Optional address checking is enabled by defining AXI4_READ_RESPONDER_ERR_EN.
module axi4_read_responder #(
   parameter int                 ADDR_W    = 64,
   parameter int                 DATA_W    = 64,
   parameter int                 DEPTH     = 1024,
   parameter logic [ADDR_W-1:0]  BASE_ADDR = ADDR_W'(64'h8000_0000),
   parameter int                 LATENCY   = 2,
   localparam int                IDX_W     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              read_signal,
   input  logic [ADDR_W-1:0] read_addr,
   output logic              data_arrive,
   output logic [DATA_W-1:0] data_outside,
   input  logic              load_en,
   input  logic [IDX_W-1:0]  load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              busy,
`ifdef AXI4_READ_RESPONDER_ERR_EN
   output logic              read_err,
`endif
   output logic [1:0]        state_dbg
);

   // Handshake: read_signal is held until data_arrive (a single-cycle pulse) is seen;
   // the request is captured once in IDLE and HOLD absorbs the still-high request.
   typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

   localparam logic [3:0] LAT = 4'(LATENCY);

   state_t              state, next_state;
   logic [3:0]          cnt;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W-1:0]   rd_addr;
   logic [ADDR_W-1:0]   offset;
   logic [IDX_W-1:0]    idx;
   logic [DATA_W-1:0]   mem [DEPTH];

   // With zero latency the response is built straight from the live request address.
   assign rd_addr = (state == IDLE) ? read_addr : addr_q;
   assign offset  = rd_addr - BASE_ADDR;
   assign idx     = IDX_W'(offset >> 3);

`ifdef AXI4_READ_RESPONDER_ERR_EN
   localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(DEPTH) << 3;
   logic bad_addr;
   logic err_q;
   assign bad_addr = (rd_addr[2:0] != 3'b000) || (offset >= SPAN);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (read_signal) next_state = (LAT == 4'd0) ? RESP : WAIT;
         WAIT: if (cnt == 4'd1) next_state = RESP;
         RESP: next_state = HOLD;
         HOLD: if (!read_signal) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      data_arrive = (state == RESP);
      busy        = (state != IDLE);
      state_dbg   = state;
`ifdef AXI4_READ_RESPONDER_ERR_EN
      read_err    = err_q && (state == RESP);
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt          <= 4'd0;
         addr_q       <= '0;
         data_outside <= '0;
`ifdef AXI4_READ_RESPONDER_ERR_EN
         err_q        <= 1'b0;
`endif
      end else begin
         if (state == IDLE && read_signal) begin
            addr_q <= read_addr;
            cnt    <= LAT;
         end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         // Non-blocking read: a load to the same index on this edge is not seen.
         if (next_state == RESP) begin
`ifdef AXI4_READ_RESPONDER_ERR_EN
            if (bad_addr) begin
               data_outside <= DATA_W'(64'hDEAD_BEEF_DEAD_BEEF);
               err_q        <= 1'b1;
            end else begin
               data_outside <= mem[idx];
               err_q        <= 1'b0;
            end
`else
            data_outside <= mem[idx];
`endif
         end
      end
   end

   // Array contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (load_en) mem[load_addr] <= load_data;
   end

endmodule
